fpga_rst_seq: RTL and testbench
===============================

# fpga_rst_seq

Board-level reset sequencer for the FPGA build. It sits between the clock wizard and the SoC core's `ext_rst_n_i_pad`, and produces the SoC's active-low reset. Its inputs are the clock-wizard lock and the board reset button, both debounced and synchronized. The SoC is released only after the system clock is stable and a fixed hold interval has elapsed. It also counts reset events for debug.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop depth for async inputs; must be ≥2.
- `DEB_CYCLES`, default 100000: consecutive stable cycles required for a button edge; must be ≥1.
- `HOLD_CYCLES`, default 256: cycles the SoC reset is held after lock or button release; must be ≥2.
- `clk_i`  in  1  system clock (`clk_wiz_0` output).
- `rst_i`  in  1  reset, synchronous, active-high.
- `locked_i`  in  1  clock-wizard lock; asynchronous.
- `btn_rst_n_i`  in  1  board reset button, active-low; asynchronous and bouncy.
- `soc_rst_n_o`  out  1  registered SoC reset, active-low; drives `ext_rst_n_i_pad`.
- `state_o`  out  2  FSM state: 0 WAIT_LOCK, 1 HOLD, 2 RUN, 3 BTN_WAIT.
- `rst_cnt_o`  out  8  saturating count of resets issued from RUN.

## Operation
**Reset values.** While `rst_i` is high, every register takes its reset value at each edge:
- state = WAIT_LOCK, `soc_rst_n_o` = 0, `rst_cnt_o` = 0.
- hold_cnt = 0, deb_cnt = 0.
- lock synchronizer chain = 0; button synchronizer chain = 1; btn_db = 1 (released).

**Synchronizers.** `locked_i` and `btn_rst_n_i` each pass through `SYNC_STAGES` flops, giving lock_s and btn_s.

**Debouncer.**
- deb_cnt counts cycles where btn_s != btn_db.
- Any cycle with btn_s == btn_db clears deb_cnt.
- On a mismatch cycle with deb_cnt == DEB_CYCLES-1: btn_db flips and deb_cnt clears.
- Width is clog2(DEB_CYCLES), minimum 1.

**FSM.** Transitions are evaluated in the listed priority order.
- WAIT_LOCK:
  - lock_s=1 → HOLD, hold_cnt←0.
- HOLD: hold_cnt increments every cycle.
  - lock_s=0 → WAIT_LOCK.
  - btn_db=0 → BTN_WAIT.
  - hold_cnt==HOLD_CYCLES-1 → RUN.
- RUN:
  - lock_s=0 → WAIT_LOCK, rst_cnt+1.
  - btn_db=0 → BTN_WAIT, rst_cnt+1.
  - If both occur in the same cycle: go to WAIT_LOCK and increment once.
- BTN_WAIT:
  - lock_s=0 → WAIT_LOCK.
  - btn_db=1 → HOLD, hold_cnt←0.

**Counters and outputs.**
- rst_cnt saturates at 255; increments beyond that are dropped.
- hold_cnt width is clog2(HOLD_CYCLES).
- `soc_rst_n_o` ← (next_state == RUN), so it is high exactly while `state_o` == 2. It never glitches.
- `state_o` is the state register itself.

## Timing
**Release latency.**
- `locked_i` rise is sampled at edge k. lock_s is high after edge k+SYNC_STAGES-1. The FSM enters HOLD at edge k+SYNC_STAGES.
- `soc_rst_n_o` rises at edge k+SYNC_STAGES+HOLD_CYCLES. With defaults that is k+258.

**Button assertion.**
- Button low sampled at edge k. btn_db falls at edge k+SYNC_STAGES-1+DEB_CYCLES.
- `soc_rst_n_o` falls one edge later.

**Button release.**
- Same debounce latency as assertion. The FSM then spends HOLD_CYCLES in HOLD before entering RUN.

**Lock loss.**
- `soc_rst_n_o` falls at edge k+SYNC_STAGES. No debounce is applied to lock.

**Boundary cases.**
- Bounces shorter than DEB_CYCLES consecutive cycles have no effect.
- A button held across power-up: WAIT_LOCK → HOLD → BTN_WAIT; the FSM stays there until release.
- `rst_i` asserted mid-RUN: `soc_rst_n_o` is 0 after that edge and rst_cnt clears. That event is not counted.

## Test plan
Bench parameters: SYNC_STAGES=2, DEB_CYCLES=8, HOLD_CYCLES=16.
1. Power-up:
   - Stimulus: `rst_i` high for 4 cycles, button high, `locked_i` rises at edge 10.
   - Required: `state_o` = 1 at edge 12; `soc_rst_n_o` = 1 and `state_o` = 2 at edge 28; `rst_cnt_o` = 0.
2. Bounce rejection:
   - Stimulus: in RUN, button low for 7 cycles, high for 1, then low for 7.
   - Required: `soc_rst_n_o` stays 1; `rst_cnt_o` = 0.
3. Button press and release:
   - Stimulus: in RUN, button low at edge k for 30 cycles, then high.
   - Required: `soc_rst_n_o` = 0 and `state_o` = 3 at edge k+10; `rst_cnt_o` = 1; `soc_rst_n_o` = 1 again at edge k+30+9+16+1.
4. Lock loss in HOLD and simultaneous events in RUN:
   - Stimulus: drop lock at HOLD cycle 5.
   - Required: WAIT_LOCK, `rst_cnt_o` unchanged.
   - Stimulus: in RUN, lock_s falls on the same edge btn_db falls.
   - Required: `state_o` = 0; `rst_cnt_o` increments by exactly 1.
5. Saturation:
   - Stimulus: 260 debounced press/release cycles.
   - Required: `rst_cnt_o` = 255 and holds there.
6. Reset mid-operation:
   - Stimulus: `rst_i` pulsed 1 cycle in RUN with `rst_cnt_o` = 3.
   - Required: next edge `soc_rst_n_o` = 0, `state_o` = 0, `rst_cnt_o` = 0; re-release 18 cycles after `rst_i` falls if lock is held.

Source files
------------

// File: rtl/fpga_rst_seq.sv
// rtl/fpga_rst_seq.sv - board reset sequencer: lock/button sync, button debounce, SoC reset FSM
module fpga_rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 100000,
    parameter int HOLD_CYCLES = 256
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       locked_i,
    input  logic       btn_rst_n_i,
    output logic       soc_rst_n_o,
    output logic [1:0] state_o,
    output logic [7:0] rst_cnt_o
);

    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2,
        BTN_WAIT  = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   lock_s;
    logic                   btn_s;
    logic                   btn_db;
    logic [DEB_W-1:0]       deb_cnt;
    logic [HOLD_W-1:0]      hold_cnt;

    assign lock_s  = lock_sync[SYNC_STAGES-1];
    assign btn_s   = btn_sync[SYNC_STAGES-1];
    assign state_o = state;

    // Bring the asynchronous lock and button into the clock domain; the button idles released.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_sync <= '0;
            btn_sync  <= '1;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked_i};
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_rst_n_i};
        end
    end

    // Debounce: btn_db follows btn_s only after DEB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_db  <= 1'b1;
            deb_cnt <= '0;
        end else if (btn_s == btn_db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            btn_db  <= btn_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Reset sequencing FSM; soc_rst_n_o is registered from the state being entered, so it is
    // high exactly while the state register holds RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= WAIT_LOCK;
            soc_rst_n_o <= 1'b0;
            rst_cnt_o   <= 8'd0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    soc_rst_n_o <= 1'b0;
                    if (lock_s) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    hold_cnt    <= hold_cnt + 1'b1;
                    soc_rst_n_o <= 1'b0;
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (!btn_db) begin
                        state <= BTN_WAIT;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state       <= RUN;
                        soc_rst_n_o <= 1'b1;
                    end
                end
                RUN: begin
                    // Lock loss wins over a simultaneous button press; either counts once.
                    if (!lock_s || !btn_db) begin
                        state       <= lock_s ? BTN_WAIT : WAIT_LOCK;
                        soc_rst_n_o <= 1'b0;
                        if (rst_cnt_o != 8'hFF) begin
                            rst_cnt_o <= rst_cnt_o + 8'd1;
                        end
                    end else begin
                        soc_rst_n_o <= 1'b1;
                    end
                end
                BTN_WAIT: begin
                    soc_rst_n_o <= 1'b0;
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (btn_db) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state       <= WAIT_LOCK;
                    soc_rst_n_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_rst_seq.sv
// tb/tb_fpga_rst_seq.sv - directed self-checking bench for fpga_rst_seq
module tb_fpga_rst_seq;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       btn_n;
    logic       soc_rst_n;
    logic [1:0] state;
    logic [7:0] rst_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    fpga_rst_seq #(
        .SYNC_STAGES(2),
        .DEB_CYCLES (8),
        .HOLD_CYCLES(16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .locked_i   (locked),
        .btn_rst_n_i(btn_n),
        .soc_rst_n_o(soc_rst_n),
        .state_o    (state),
        .rst_cnt_o  (rst_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Steps until RUN is reached or the budget expires; ok reports which.
    task automatic wait_run(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (state == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; locked = 1'b0; btn_n = 1'b1;
        step(1);
        chk_cnt++;
        if (state !== 2'd0 || soc_rst_n !== 1'b0 || rst_cnt !== 8'd0)
            $display("FAIL reset_values: state=%0d soc=%0b cnt=%0d, want 0/0/0", state, soc_rst_n, rst_cnt);
        else pass_cnt++;
    endtask

    task automatic test_power_up;
        step(3);              // edges 2..4 with reset high
        rst = 1'b0;
        step(5);              // edges 5..9
        locked = 1'b1;        // sampled at edge 10
        step(2);              // edge 11
        chk_cnt++;
        if (state !== 2'd0) $display("FAIL pu_state_e11: state=%0d, want 0", state);
        else pass_cnt++;
        step(1);              // edge 12
        chk_cnt++;
        if (state !== 2'd1) $display("FAIL pu_state_e12: state=%0d, want 1", state);
        else pass_cnt++;
        step(15);             // edge 27
        chk_cnt++;
        if (state !== 2'd1 || soc_rst_n !== 1'b0)
            $display("FAIL pu_e27: state=%0d soc=%0b, want 1/0", state, soc_rst_n);
        else pass_cnt++;
        step(1);              // edge 28
        chk_cnt++;
        if (state !== 2'd2 || soc_rst_n !== 1'b1 || rst_cnt !== 8'd0)
            $display("FAIL pu_e28: state=%0d soc=%0b cnt=%0d, want 2/1/0", state, soc_rst_n, rst_cnt);
        else pass_cnt++;
    endtask

    task automatic test_bounce;
        bit dropped = 1'b0;
        btn_n = 1'b0;
        for (int i = 0; i < 7; i++) begin step(1); if (soc_rst_n !== 1'b1) dropped = 1'b1; end
        btn_n = 1'b1;
        step(1); if (soc_rst_n !== 1'b1) dropped = 1'b1;
        btn_n = 1'b0;
        for (int i = 0; i < 7; i++) begin step(1); if (soc_rst_n !== 1'b1) dropped = 1'b1; end
        btn_n = 1'b1;
        for (int i = 0; i < 12; i++) begin step(1); if (soc_rst_n !== 1'b1) dropped = 1'b1; end
        chk_cnt++;
        if (dropped) $display("FAIL bounce_soc: soc dropped to 0, want stays 1");
        else pass_cnt++;
        chk_cnt++;
        if (rst_cnt !== 8'd0 || state !== 2'd2)
            $display("FAIL bounce_cnt: cnt=%0d state=%0d, want 0/2", rst_cnt, state);
        else pass_cnt++;
    endtask

    task automatic test_button_press_release;
        btn_n = 1'b0;
        step(1);              // edge k
        step(9);              // edge k+9
        chk_cnt++;
        if (soc_rst_n !== 1'b1 || state !== 2'd2)
            $display("FAIL btn_k9: soc=%0b state=%0d, want 1/2", soc_rst_n, state);
        else pass_cnt++;
        step(1);              // edge k+10
        chk_cnt++;
        if (soc_rst_n !== 1'b0 || state !== 2'd3 || rst_cnt !== 8'd1)
            $display("FAIL btn_k10: soc=%0b state=%0d cnt=%0d, want 0/3/1", soc_rst_n, state, rst_cnt);
        else pass_cnt++;
        step(19);             // edge k+29
        btn_n = 1'b1;         // sampled at k+30
        step(26);             // edge k+55
        chk_cnt++;
        if (soc_rst_n !== 1'b0 || state !== 2'd1)
            $display("FAIL rel_k55: soc=%0b state=%0d, want 0/1", soc_rst_n, state);
        else pass_cnt++;
        step(1);              // edge k+56
        chk_cnt++;
        if (soc_rst_n !== 1'b1 || state !== 2'd2 || rst_cnt !== 8'd1)
            $display("FAIL rel_k56: soc=%0b state=%0d cnt=%0d, want 1/2/1", soc_rst_n, state, rst_cnt);
        else pass_cnt++;
    endtask

    task automatic test_lock_loss;
        bit ok;
        locked = 1'b0;
        step(1);              // edge k
        step(1);              // edge k+1
        chk_cnt++;
        if (soc_rst_n !== 1'b1) $display("FAIL lockloss_k1: soc=%0b, want 1", soc_rst_n);
        else pass_cnt++;
        step(1);              // edge k+2
        chk_cnt++;
        if (soc_rst_n !== 1'b0 || state !== 2'd0 || rst_cnt !== 8'd2)
            $display("FAIL lockloss_k2: soc=%0b state=%0d cnt=%0d, want 0/0/2", soc_rst_n, state, rst_cnt);
        else pass_cnt++;
        locked = 1'b1;
        step(3);              // HOLD entered at this edge
        chk_cnt++;
        if (state !== 2'd1) $display("FAIL hold_entry: state=%0d, want 1", state);
        else pass_cnt++;
        step(2);
        locked = 1'b0;        // sampled in HOLD cycle 3, FSM leaves two edges later
        step(2);
        chk_cnt++;
        if (state !== 2'd1) $display("FAIL hold_drop_pre: state=%0d, want 1", state);
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if (state !== 2'd0 || rst_cnt !== 8'd2 || soc_rst_n !== 1'b0)
            $display("FAIL hold_drop: state=%0d cnt=%0d soc=%0b, want 0/2/0", state, rst_cnt, soc_rst_n);
        else pass_cnt++;
        locked = 1'b1;
        wait_run(60, ok);
        chk_cnt++;
        if (!ok) $display("FAIL relock_run: state=%0d, want 2 within 60 cycles", state);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous;
        bit ok;
        btn_n = 1'b0;
        step(1);              // edge k
        step(7);              // edge k+7
        locked = 1'b0;        // sampled k+8, lock_s falls at k+9 with btn_db
        step(2);              // edge k+9
        chk_cnt++;
        if (state !== 2'd2) $display("FAIL simul_k9: state=%0d, want 2", state);
        else pass_cnt++;
        step(1);              // edge k+10
        chk_cnt++;
        if (state !== 2'd0 || rst_cnt !== 8'd3)
            $display("FAIL simul_k10: state=%0d cnt=%0d, want 0/3", state, rst_cnt);
        else pass_cnt++;
        btn_n = 1'b1;
        locked = 1'b1;
        wait_run(100, ok);
        chk_cnt++;
        if (!ok || rst_cnt !== 8'd3)
            $display("FAIL simul_recover: state=%0d cnt=%0d, want 2/3", state, rst_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run;
        rst = 1'b1;
        step(1);              // edge r
        rst = 1'b0;
        chk_cnt++;
        if (soc_rst_n !== 1'b0 || state !== 2'd0 || rst_cnt !== 8'd0)
            $display("FAIL midrst_r: soc=%0b state=%0d cnt=%0d, want 0/0/0", soc_rst_n, state, rst_cnt);
        else pass_cnt++;
        step(3);              // edge r+3
        chk_cnt++;
        if (state !== 2'd1) $display("FAIL midrst_hold: state=%0d, want 1", state);
        else pass_cnt++;
        step(15);             // edge r+18
        chk_cnt++;
        if (soc_rst_n !== 1'b0) $display("FAIL midrst_r18: soc=%0b, want 0", soc_rst_n);
        else pass_cnt++;
        step(1);              // edge r+19: first low edge + 2 sync + 16 hold
        chk_cnt++;
        if (soc_rst_n !== 1'b1 || state !== 2'd2 || rst_cnt !== 8'd0)
            $display("FAIL midrst_r19: soc=%0b state=%0d cnt=%0d, want 1/2/0", soc_rst_n, state, rst_cnt);
        else pass_cnt++;
    endtask

    task automatic test_saturation;
        bit ok;
        bit all_ok = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            btn_n = 1'b0;
            step(12);
            btn_n = 1'b1;
            wait_run(60, ok);
            if (!ok) all_ok = 1'b0;
            if (i == 254) begin
                chk_cnt++;
                if (rst_cnt !== 8'd254) $display("FAIL sat_254: cnt=%0d, want 254", rst_cnt);
                else pass_cnt++;
            end
            if (i == 255) begin
                chk_cnt++;
                if (rst_cnt !== 8'd255) $display("FAIL sat_255: cnt=%0d, want 255", rst_cnt);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (!all_ok) $display("FAIL sat_cycles: RUN not reached in some press cycle");
        else pass_cnt++;
        chk_cnt++;
        if (rst_cnt !== 8'd255) $display("FAIL sat_hold: cnt=%0d, want 255", rst_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_bounce();
        test_button_press_release();
        test_lock_loss();
        test_simultaneous();
        test_reset_mid_run();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
